// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmit FSM states and baud divisor helper.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   // Bit period in sysclk cycles, truncating.
   function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte handshake between the CPU-side peripheral bus and the UART transmitter.
interface uart_tx_engine_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx_valid;
   logic                      tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Small power-of-two byte queue with registered count; rejects pushes while full.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     sysclk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_c,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head_c  = mem[rd_ptr];

   always_ff @(posedge sysclk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered 8N1 UART transmitter: FIFO-fed frame FSM with a flop-driven serial line.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              sysclk,
   input  logic              reset,
   uart_tx_engine_if.slave   bus,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              UART_TX
);

   localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD);
   localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
   localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_engine: CLK_FREQ / BAUD must be at least 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_engine: FIFO_DEPTH must be a power of two >= 2");
   end

   uart_tx_state_t              state_q, state_d;
   logic [CNT_W-1:0]            baud_q, baud_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
   logic                        line_q, line_d;
   logic                        pop_c;
   logic                        bit_end_c;
   logic [UART_DATA_BITS-1:0]   fifo_head_c;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [FCW-1:0]              fifo_count;

   uart_tx_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sysclk (sysclk),
      .reset  (reset),
      .push   (bus.tx_valid),
      .wdata  (bus.tx_data),
      .pop    (pop_c),
      .head_c (fifo_head_c),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign bus.tx_ready = !fifo_full;
   assign tx_busy      = (state_q != IDLE) || (fifo_count != '0);
   assign bit_end_c    = (baud_q == CNT_W'(DIV - 1));
   assign UART_TX      = line_q;

   // Next-state logic; line_d is the value the line shows for the coming bit.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      line_d  = line_q;
      pop_c   = 1'b0;
      tx_done = 1'b0;
      if (state_q != IDLE) baud_d = bit_end_c ? '0 : baud_q + CNT_W'(1);
      unique case (state_q)
         IDLE: begin
            line_d = 1'b1;
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               shift_d = fifo_head_c;
               baud_d  = '0;
               line_d  = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end_c) begin
               idx_d   = '0;
               line_d  = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end_c) begin
               shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               if (idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
                  line_d  = 1'b1;
                  state_d = STOP;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  line_d = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end_c) begin
               tx_done = 1'b1;
               if (!fifo_empty) begin
                  pop_c   = 1'b1;
                  shift_d = fifo_head_c;
                  line_d  = 1'b0;
                  state_d = START;
               end else begin
                  line_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         line_q  <= line_d;
      end
   end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Buffered UART transmitter. It accepts bytes from the CPU-side peripheral bus through a valid/ready handshake and queues them in a small FIFO. Each byte is serialised onto `UART_TX` as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) at a fixed baud rate derived from `sysclk`. It is the transmit-direction counterpart of the UART receive path and sits beside it in the UART peripheral.

## Interface

Parameters:
- `CLK_FREQ`, default 100_000_000: `sysclk` frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `FIFO_DEPTH`, default 4: byte queue depth; a power of two, ≥ 2.

Ports:
- `sysclk` (input, 1): the single clock; all logic is on its rising edge.
- `reset` (input, 1): synchronous, active-high reset.
- `tx_data` (input, 8): byte to send.
- `tx_valid` (input, 1): `tx_data` is valid this cycle.
- `tx_ready` (output, 1): the FIFO can accept a byte this cycle.
- `tx_busy` (output, 1): a frame is in progress or the FIFO is non-empty.
- `tx_done` (output, 1): one-cycle pulse marking the end of each stop bit.
- `UART_TX` (output, 1): serial line, idle high.

## Operation

- Bit period `DIV = CLK_FREQ / BAUD`, with integer truncation (10416 at the defaults).
  - Elaboration fails if `DIV < 2`.
  - The baud counter is `$clog2(DIV)` bits wide and counts 0..DIV-1.
- A byte is accepted on any rising edge where `tx_valid && tx_ready`.
  - `tx_ready = (count != FIFO_DEPTH)` and depends only on the registered count.
  - When the FIFO is full, a push in the same cycle as a pop is still rejected.
  - `tx_data` is ignored whenever the handshake does not complete.
- FSM states and transitions:
  - IDLE: `UART_TX = 1`. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and go to START.
  - START: `UART_TX = 0` for DIV cycles, then go to DATA with bit index 0.
  - DATA: `UART_TX = shift[0]` for DIV cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `UART_TX = 1` for DIV cycles. On the last cycle, pulse `tx_done`.
    - If the FIFO is non-empty, pop and go directly to START. Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- `UART_TX` is driven from a flop. It never glitches and never changes except at bit boundaries.
- `tx_busy = (state != IDLE) || (count != 0)`, registered-equivalent with no combinational path from `tx_valid`.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`. The count is one bit wider.
- Simultaneous push and pop with the FIFO neither empty nor full: the count is unchanged and both pointers advance.
- Reset values: state IDLE, `UART_TX = 1`, `tx_ready = 1`, `tx_busy = 0`, `tx_done = 0`, count 0, pointers 0.
- Reset mid-frame aborts the frame immediately. `UART_TX` returns high on the next edge and queued bytes are discarded.

## Timing

- Accepting edge k with the FIFO empty and the FSM in IDLE:
  - The count becomes 1 after edge k.
  - IDLE pops at edge k+1, and `UART_TX` falls after edge k+1. Latency is 2 cycles.
- Frame length is exactly 10·DIV cycles.
  - The start bit begins at the pop edge.
  - Data bit n begins (1+n)·DIV cycles later.
  - `tx_done` is high during the final cycle of the stop bit.
- With a gapless follow-on frame, the next start bit begins on the edge right after the `tx_done` cycle.
- `tx_ready` rises one cycle after the pop that frees a full FIFO.
- Capacity before `tx_ready` drops: `FIFO_DEPTH` queued bytes plus 1 byte already in the shift register.

## Structure

- Shared package `uart_pkg`:
  - constants `UART_DATA_BITS = 8` and `UART_FRAME_BITS = 10`
  - the FSM state enum `uart_tx_state_t` (IDLE, START, DATA, STOP)
  - the function `baud_div(clk_freq, baud)`

  The receive path imports the same package.
- Sub-module `uart_tx_fifo`:
  - parameters: width, depth
  - outputs: `full`, `empty`, `count`
  - synchronous reset

  The top level holds the FSM, the baud counter, the bit index and the shift register.

## Test plan

Use `CLK_FREQ=16`, `BAUD=1` (DIV=16) and `FIFO_DEPTH=4` unless noted.

1. Reset for 3 cycles, then hold idle for 50 cycles → `UART_TX=1`, `tx_ready=1`, `tx_busy=0`, `tx_done=0` throughout.
2. Push 0x55 at edge k → `UART_TX` falls after edge k+1; line samples at bit centres read 0,1,0,1,0,1,0,1,0,1; `tx_done` pulses at cycle k+1+160; `tx_busy` then drops.
3. Push 0xA3, 0x00, 0xFF on consecutive cycles → 30 contiguous bit periods with no idle high between frames; decoded bytes are 0xA3, 0x00, 0xFF; 3 `tx_done` pulses, 160 cycles apart.
4. Hold `tx_valid=1` with incrementing data for 8 cycles → exactly 5 bytes accepted (1 in the shifter, 4 queued); `tx_ready` is low from the cycle after the 5th accept until the first frame's stop-bit pop; the rejected bytes never appear on the line.
5. Assert `reset` during DATA bit 3 with 2 bytes queued → `UART_TX=1` on the next edge; the count is 0; no further frames and no `tx_done`.
6. Defaults (`CLK_FREQ=100 MHz`, `BAUD=9600`): send 0x4B → each bit lasts exactly 10416 cycles; an external receiver model decodes 0x4B.
